bin_to_bcd_seq: RTL and testbench

Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock. Sits directly upstream of the seven-segment/nixie tube display driver. It turns a raw binary measurement (e.g. ADC code) into packed BCD digits, which the driver multiplexes onto the tubes. A start/busy/done handshake lets the producer launch conversions at its own rate; the result register holds its value between conversions.

---
 rtl/bin_to_bcd_seq_if.sv | 40 ++++
 rtl/bin_to_bcd_seq.sv | 140 ++++++++++++++
 tb/tb_bin_to_bcd_seq.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/bin_to_bcd_seq_if.sv
// -----------------------------------------------------------------------------
// bin_to_bcd_seq_if
// Handshake/data bundle between a binary producer and the bin_to_bcd_seq
// converter.
//   Start     producer -> converter  conversion request (honoured when Busy=0)
//   Data_Bin  producer -> converter  unsigned binary operand, BIN_W bits
//   Busy      converter -> producer  conversion in progress
//   Done      converter -> producer  one-cycle pulse, result just updated
//   Data_BCD  converter -> producer  packed BCD, digit 0 in bits [3:0]
//   Overflow  converter -> producer  value did not fit in DIG digits
// -----------------------------------------------------------------------------
interface bin_to_bcd_seq_if #(
   parameter int BIN_W = 16,
   parameter int DIG   = 5
);
   logic               Start;
   logic [BIN_W-1:0]   Data_Bin;
   logic               Busy;
   logic               Done;
   logic [4*DIG-1:0]   Data_BCD;
   logic               Overflow;

   modport master (
      output Start,
      output Data_Bin,
      input  Busy,
      input  Done,
      input  Data_BCD,
      input  Overflow
   );

   modport slave (
      input  Start,
      input  Data_Bin,
      output Busy,
      output Done,
      output Data_BCD,
      output Overflow
   );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// -----------------------------------------------------------------------------
// bin_to_bcd_seq
// Sequential binary-to-BCD converter (shift-and-add-3 / double dabble), one
// input bit per clock. Feeds the display driver with packed BCD digits.
//
// Ports:
//   Sys_CLK    in   system clock, rising edge
//   Sys_RST_N  in   asynchronous active-low reset
//   bcd_if     slave modport of bin_to_bcd_seq_if:
//                Start/Data_Bin in, Busy/Done/Data_BCD/Overflow out
//
// A conversion accepted at edge k completes (Done=1) after edge k+BIN_W.
// Data_BCD/Overflow hold between completions; an overflowing value is
// displayed as all nines.
// -----------------------------------------------------------------------------
module bin_to_bcd_seq #(
   parameter int BIN_W = 16,
   parameter int DIG   = 5
) (
   input logic            Sys_CLK,
   input logic            Sys_RST_N,
   bin_to_bcd_seq_if.slave bcd_if
);

   localparam int SCR_W = 4 * DIG;
   localparam int CNT_W = $clog2(BIN_W + 1);

   typedef enum logic {
      IDLE = 1'b0,
      CONV = 1'b1
   } state_t;

   // Digits >= 5 get +3 before the shift; max result is 12, so no digit
   // ever carries into its neighbour.
   function automatic logic [SCR_W-1:0] add3_digits(input logic [SCR_W-1:0] s);
      logic [SCR_W-1:0] r;
      r = s;
      for (int i = 0; i < DIG; i++) begin
         if (s[4*i +: 4] >= 4'd5) begin
            r[4*i +: 4] = s[4*i +: 4] + 4'd3;
         end
      end
      return r;
   endfunction

   // Display saturation: an out-of-range value shows as all nines.
   function automatic logic [SCR_W-1:0] sat_bcd(input logic [SCR_W-1:0] s,
                                                input logic             ovf);
      return ovf ? {DIG{4'h9}} : s;
   endfunction

   state_t             state_q, state_d;
   logic [BIN_W-1:0]   bin_q,   bin_d;
   logic [SCR_W-1:0]   scr_q,   scr_d;
   logic               flag_q,  flag_d;
   logic [CNT_W-1:0]   cnt_q,   cnt_d;
   logic               busy_q,  busy_d;
   logic               done_q,  done_d;
   logic [SCR_W-1:0]   bcd_q,   bcd_d;
   logic               ovf_q,   ovf_d;

   logic [SCR_W-1:0]         scr_adj;
   logic [SCR_W+BIN_W-1:0]   shifted;

   always_comb begin
      state_d = state_q;
      bin_d   = bin_q;
      scr_d   = scr_q;
      flag_d  = flag_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      bcd_d   = bcd_q;
      ovf_d   = ovf_q;

      scr_adj = add3_digits(scr_q);
      shifted = {scr_adj, bin_q} << 1;

      case (state_q)
         IDLE: begin
            if (bcd_if.Start) begin
               bin_d   = bcd_if.Data_Bin;
               scr_d   = '0;
               flag_d  = 1'b0;
               cnt_d   = CNT_W'(BIN_W);
               state_d = CONV;
               busy_d  = 1'b1;
            end
         end
         CONV: begin
            bin_d  = shifted[BIN_W-1:0];
            scr_d  = shifted[SCR_W+BIN_W-1:BIN_W];
            // A one leaving the top digit means the value needs more digits.
            flag_d = flag_q | scr_adj[SCR_W-1];
            cnt_d  = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               bcd_d   = sat_bcd(scr_d, flag_d);
               ovf_d   = flag_d;
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge Sys_CLK or negedge Sys_RST_N) begin
      if (!Sys_RST_N) begin
         state_q <= IDLE;
         bin_q   <= '0;
         scr_q   <= '0;
         flag_q  <= 1'b0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         bcd_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         bin_q   <= bin_d;
         scr_q   <= scr_d;
         flag_q  <= flag_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         bcd_q   <= bcd_d;
         ovf_q   <= ovf_d;
      end
   end

   assign bcd_if.Busy     = busy_q;
   assign bcd_if.Done     = done_q;
   assign bcd_if.Data_BCD = bcd_q;
   assign bcd_if.Overflow = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// -----------------------------------------------------------------------------
// tb_bin_to_bcd_seq
// Scoreboard bench for bin_to_bcd_seq. Two instances: A (BIN_W=16, DIG=5)
// and B (BIN_W=10, DIG=3). Accepted requests push the decimal reference
// result into a per-instance queue; a negedge monitor pops it on Done and
// checks Busy/Done timing and the held result every cycle.
// -----------------------------------------------------------------------------
module tb_bin_to_bcd_seq;

   logic clk;
   logic rst_n;

   int n_tests = 0;
   int n_fail  = 0;

   bin_to_bcd_seq_if #(.BIN_W(16), .DIG(5)) ifa ();
   bin_to_bcd_seq_if #(.BIN_W(10), .DIG(3)) ifb ();

   bin_to_bcd_seq #(.BIN_W(16), .DIG(5)) dut_a (
      .Sys_CLK   (clk),
      .Sys_RST_N (rst_n),
      .bcd_if    (ifa.slave)
   );

   bin_to_bcd_seq #(.BIN_W(10), .DIG(3)) dut_b (
      .Sys_CLK   (clk),
      .Sys_RST_N (rst_n),
      .bcd_if    (ifb.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s at %0t", name, $time);
   endtask

   // Decimal reference: digits by division, saturate when v >= 10^dig.
   function automatic logic [32:0] ref_conv(input int unsigned v, input int dig);
      logic [31:0] bcd;
      logic        ovf;
      longint unsigned lim;
      int unsigned tmp;
      lim = 1;
      for (int i = 0; i < dig; i++) lim = lim * 10;
      ovf = (longint'(v) >= lim);
      bcd = '0;
      tmp = v;
      for (int i = 0; i < dig; i++) begin
         bcd[4*i +: 4] = ovf ? 4'd9 : 4'(tmp % 10);
         tmp = tmp / 10;
      end
      return {ovf, bcd};
   endfunction

   // ---------------- instance A model / scoreboard ----------------
   int          rem_a = 0;
   logic        done_exp_a = 1'b0;
   logic [32:0] q_a[$];
   logic [31:0] hold_a = '0;
   logic        hold_ovf_a = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem_a = 0;
         done_exp_a = 1'b0;
         q_a.delete();
      end else begin
         done_exp_a = 1'b0;
         if (rem_a != 0) begin
            rem_a--;
            if (rem_a == 0) done_exp_a = 1'b1;
         end else if (ifa.Start) begin
            rem_a = 16;
            q_a.push_back(ref_conv(int'(ifa.Data_Bin), 5));
         end
      end
   end

   always @(negedge clk) begin
      logic [32:0] e;
      logic bad;
      chk("a_busy", 32'(ifa.Busy), 32'(rem_a != 0));
      chk("a_done", 32'(ifa.Done), 32'(done_exp_a));
      if (!rst_n) begin
         hold_a = '0;
         hold_ovf_a = 1'b0;
      end else if (ifa.Done) begin
         if (q_a.size() == 0) begin
            fail_now("a_unexpected_done");
         end else begin
            e = q_a.pop_front();
            hold_a = e[31:0];
            hold_ovf_a = e[32];
            bad = 1'b0;
            for (int i = 0; i < 5; i++) if (ifa.Data_BCD[4*i +: 4] > 4'd9) bad = 1'b1;
            chk("a_nibble_valid", 32'(bad), 32'd0);
         end
      end
      chk("a_bcd", 32'(ifa.Data_BCD), hold_a);
      chk("a_ovf", 32'(ifa.Overflow), 32'(hold_ovf_a));
   end

   // ---------------- instance B model / scoreboard ----------------
   int          rem_b = 0;
   logic        done_exp_b = 1'b0;
   logic [32:0] q_b[$];
   logic [31:0] hold_b = '0;
   logic        hold_ovf_b = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem_b = 0;
         done_exp_b = 1'b0;
         q_b.delete();
      end else begin
         done_exp_b = 1'b0;
         if (rem_b != 0) begin
            rem_b--;
            if (rem_b == 0) done_exp_b = 1'b1;
         end else if (ifb.Start) begin
            rem_b = 10;
            q_b.push_back(ref_conv(int'(ifb.Data_Bin), 3));
         end
      end
   end

   always @(negedge clk) begin
      logic [32:0] e;
      logic bad;
      chk("b_busy", 32'(ifb.Busy), 32'(rem_b != 0));
      chk("b_done", 32'(ifb.Done), 32'(done_exp_b));
      if (!rst_n) begin
         hold_b = '0;
         hold_ovf_b = 1'b0;
      end else if (ifb.Done) begin
         if (q_b.size() == 0) begin
            fail_now("b_unexpected_done");
         end else begin
            e = q_b.pop_front();
            hold_b = e[31:0];
            hold_ovf_b = e[32];
            bad = 1'b0;
            for (int i = 0; i < 3; i++) if (ifb.Data_BCD[4*i +: 4] > 4'd9) bad = 1'b1;
            chk("b_nibble_valid", 32'(bad), 32'd0);
         end
      end
      chk("b_bcd", 32'(ifb.Data_BCD), hold_b);
      chk("b_ovf", 32'(ifb.Overflow), 32'(hold_ovf_b));
   end

   // ---------------- stimulus helpers ----------------
   task automatic go_a(input int unsigned v);
      @(negedge clk);
      ifa.Start = 1'b1;
      ifa.Data_Bin = 16'(v);
      @(negedge clk);
      ifa.Start = 1'b0;
   endtask

   task automatic go_b(input int unsigned v);
      @(negedge clk);
      ifb.Start = 1'b1;
      ifb.Data_Bin = 10'(v);
      @(negedge clk);
      ifb.Start = 1'b0;
   endtask

   task automatic wait_idle_a();
      int n = 0;
      while (ifa.Busy !== 1'b0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) fail_now("a_busy_timeout");
      @(negedge clk);
   endtask

   task automatic wait_idle_b();
      int n = 0;
      while (ifb.Busy !== 1'b0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) fail_now("b_busy_timeout");
      @(negedge clk);
   endtask

   initial begin
      ifa.Start = 1'b0;
      ifa.Data_Bin = '0;
      ifb.Start = 1'b0;
      ifb.Data_Bin = '0;
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;

      // zero operand
      go_a(0);
      wait_idle_a();

      // back-to-back with Start held high: 1234 then 65535
      @(negedge clk);
      ifa.Start = 1'b1;
      ifa.Data_Bin = 16'd1234;
      @(negedge clk);
      ifa.Data_Bin = 16'd65535;
      repeat (17) @(negedge clk);
      ifa.Start = 1'b0;
      wait_idle_a();

      // Start while busy is ignored
      go_a(42);
      repeat (5) @(negedge clk);
      go_a(7);
      wait_idle_a();
      repeat (20) @(negedge clk);

      // completed conversion, then async reset mid-conversion
      go_a(321);
      wait_idle_a();
      go_a(4095);
      repeat (6) @(negedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_busy", 32'(ifa.Busy), 32'd0);
      chk("rst_done", 32'(ifa.Done), 32'd0);
      chk("rst_bcd",  32'(ifa.Data_BCD), 32'd0);
      chk("rst_ovf",  32'(ifa.Overflow), 32'd0);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      repeat (25) @(negedge clk);
      go_a(77);
      wait_idle_a();

      // random sweep on A
      for (int i = 0; i < 1000; i++) begin
         go_a($urandom_range(0, 65535));
         wait_idle_a();
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      // narrow instance: boundary around 10^3
      go_b(999);
      wait_idle_b();
      go_b(1000);
      wait_idle_b();
      go_b(5);
      wait_idle_b();
      go_b(1023);
      wait_idle_b();
      for (int i = 0; i < 30; i++) begin
         go_b($urandom_range(0, 1023));
         wait_idle_b();
      end

      repeat (5) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
